fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, 8, queue entries; power of two, >= 4.
REQ-002 Clock is clk and reset is reset; one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 validf  in  1  fetch presents an instruction pair this cycle.
REQ-006 singlef  in  1  only instrf valid (instrf2 ignored) when validf high.
REQ-007 instrf, instrf2  in  32 each  fetched instructions, program order.
REQ-008 pcplus4f  in  32  PC+4 of instrf; PC+4 of instrf2 is pcplus4f+4.
REQ-009 readyf  out  1  queue can accept a pair (free entries >= 2).
REQ-010 taked  in  2  instructions consumed by decode this cycle (0,1,2).
REQ-011 flushd  in  1  decode redirect; discard all queued and incoming instructions.
REQ-012 instrd, instrd2  out  32 each  head and head+1 instructions to decode.
REQ-013 pcplus4d, pcplus4d2  out  32 each  PC+4 of head and head+1.
REQ-014 validd, validd2  out  1 each  head / head+1 entry present.
REQ-015 count  out  log2(DEPTH)+1  current occupancy.

Function
REQ-016 Entry = {instr[31:0], pcplus4[31:0]}; circular buffer, read/write pointers wrap modulo DEPTH.
REQ-017 Enqueue fires when validf && readyf && !flushd: writes 1 entry if singlef else 2 (instrf first).
REQ-018 validf while readyf low SHALL be dropped; fetch holds the pair until readyf.
REQ-019 Dequeue removes min(taked, count) entries from head; taked above occupancy is clipped, never underflows.
REQ-020 Simultaneous enqueue and dequeue in one cycle: count_next = count + enq - deq.
REQ-021 Written entries visible at outputs the next cycle (one-cycle fetch-to-decode latency); no same-cycle bypass.
REQ-022 Outputs are combinational reads of the head entries; validd = count>=1, validd2 = count>=2.
REQ-023 Invalid output slot drives instr = 32'h0 (MIPS nop) and pcplus4 = 32'h0.
REQ-024 readyf = (DEPTH - count >= 2) && !reset.
REQ-025 flushd has priority: next cycle count = 0, pointers equal, enqueue and dequeue that cycle discarded.
REQ-026 Pair straddling the wrap boundary (write pointer = DEPTH-1) SHALL write entries DEPTH-1 and 0.

Reset
REQ-027 While reset high: count=0, pointers=0, readyf=0, validd=validd2=0, all data outputs 0.
REQ-028 Reset mid-operation discards all entries; first cycle after reset deassert readyf=1.
REQ-029 Entry storage contents need not be reset; invalid slots are masked per REQ-023.

Configuration
REQ-030 Macro FETCH_QUEUE_STATS_EN: when defined, adds output stallcnt (32) counting cycles with validf && !readyf, cleared by reset, saturating at 32'hFFFFFFFF.
REQ-031 Without FETCH_QUEUE_STATS_EN: port stallcnt and its counter absent; all other behaviour identical.

Structure
REQ-032 Shared package holds DEPTH default, entry-width constant (64), and MIPS nop constant 32'h0.
REQ-033 One sub-module natural: fq_ram, DEPTH x 64 storage with two write ports and two combinational read ports.
REQ-034 Pointer/count logic and output masking stay in fetch_queue.

Verification
REQ-035 Reset, then pair (32'h20080001, 32'h20090002, pcplus4f=32'h00400004), taked=0 -> next cycle validd=validd2=1, pcplus4d=32'h00400004, pcplus4d2=32'h00400008, count=2.
REQ-036 Fill DEPTH=8 with 4 pairs, taked=0 -> readyf=0 at count=8; a fifth pair is dropped; taked=2 -> readyf=1 next cycle.
REQ-037 count=1, taked=2 -> count=0, validd=0, instrd=32'h0; no underflow.
REQ-038 count=3, validf pair, taked=1, same cycle -> count=4, head advanced by one, order preserved.
REQ-039 count=6, validf pair and flushd=1 same cycle -> count=0, validd=0; next pair enqueued normally.
REQ-040 Stream 20 pairs through wrap with random taked; FETCH_QUEUE_STATS_EN defined -> output order matches input order and stallcnt equals cycles with validf && !readyf.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared constants and entry type for the fetch/decode queue.
`default_nettype none

package fetch_queue_pkg;

  localparam int          c_fq_depth = 8;
  localparam int          c_entry_w  = 64;
  localparam logic [31:0] c_mips_nop = 32'h0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
  } fq_entry_t;

endpackage

`default_nettype wire

// File: rtl/fq_ram.sv
// fq_ram: DEPTH x 64 entry storage, two write ports, two combinational read ports.
`default_nettype none

module fq_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = c_fq_depth
) (
  input  logic                     clk,
  input  logic                     we0_i,
  input  logic [$clog2(DEPTH)-1:0] waddr0_i,
  input  fq_entry_t                wdata0_i,
  input  logic                     we1_i,
  input  logic [$clog2(DEPTH)-1:0] waddr1_i,
  input  fq_entry_t                wdata1_i,
  input  logic [$clog2(DEPTH)-1:0] raddr0_i,
  input  logic [$clog2(DEPTH)-1:0] raddr1_i,
  output fq_entry_t                rdata0_o,
  output fq_entry_t                rdata1_o
);

  fq_entry_t mem_q [DEPTH];

  // The two write addresses are always consecutive, so they never collide.
  always_ff @(posedge clk) begin
    if (we0_i) mem_q[waddr0_i] <= wdata0_i;
    if (we1_i) mem_q[waddr1_i] <= wdata1_i;
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// fetch_queue: dual-issue instruction queue between fetch and decode.
// Optional FETCH_QUEUE_STATS_EN adds the stallcnt output.
`default_nettype none

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = c_fq_depth
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   validf,
  input  logic                   singlef,
  input  logic [31:0]            instrf,
  input  logic [31:0]            instrf2,
  input  logic [31:0]            pcplus4f,
  output logic                   readyf,
  input  logic [1:0]             taked,
  input  logic                   flushd,
  output logic [31:0]            instrd,
  output logic [31:0]            instrd2,
  output logic [31:0]            pcplus4d,
  output logic [31:0]            pcplus4d2,
  output logic                   validd,
  output logic                   validd2,
`ifdef FETCH_QUEUE_STATS_EN
  output logic [31:0]            stallcnt,
`endif
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          w_enq;
  logic [CW-1:0] w_enq_n, w_deq_n, w_taked;
  fq_entry_t     w_wdata0, w_wdata1, w_rdata0, w_rdata1;

  assign readyf  = ((CW'(DEPTH) - count_q) >= CW'(2)) && !reset;
  assign w_enq   = validf && readyf && !flushd;
  assign w_enq_n = w_enq ? (singlef ? CW'(1) : CW'(2)) : CW'(0);
  // Decode may ask for more than is queued; clip to occupancy.
  assign w_taked = CW'(taked);
  assign w_deq_n = (w_taked > count_q) ? count_q : w_taked;

  always_comb begin
    count_d = count_q + w_enq_n - w_deq_n;
    wptr_d  = wptr_q + AW'(w_enq_n);
    rptr_d  = rptr_q + AW'(w_deq_n);
    if (flushd) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  assign w_wdata0 = '{instr: instrf,  pcplus4: pcplus4f};
  assign w_wdata1 = '{instr: instrf2, pcplus4: pcplus4f + 32'd4};

  fq_ram #(.DEPTH(DEPTH)) u_ram (
    .clk      (clk),
    .we0_i    (w_enq),
    .waddr0_i (wptr_q),
    .wdata0_i (w_wdata0),
    .we1_i    (w_enq && !singlef),
    .waddr1_i (wptr_q + AW'(1)),
    .wdata1_i (w_wdata1),
    .raddr0_i (rptr_q),
    .raddr1_i (rptr_q + AW'(1)),
    .rdata0_o (w_rdata0),
    .rdata1_o (w_rdata1)
  );

  // Storage is never reset, so empty slots must be masked to a nop.
  assign validd    = !reset && (count_q >= CW'(1));
  assign validd2   = !reset && (count_q >= CW'(2));
  assign instrd    = validd  ? w_rdata0.instr   : c_mips_nop;
  assign pcplus4d  = validd  ? w_rdata0.pcplus4 : 32'h0;
  assign instrd2   = validd2 ? w_rdata1.instr   : c_mips_nop;
  assign pcplus4d2 = validd2 ? w_rdata1.pcplus4 : 32'h0;
  assign count     = reset ? '0 : count_q;

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stallcnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stallcnt_q <= '0;
    end else if (validf && !readyf && (stallcnt_q != 32'hFFFF_FFFF)) begin
      stallcnt_q <= stallcnt_q + 32'd1;
    end
  end

  assign stallcnt = stallcnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue (DEPTH=8).
`default_nettype none

module tb_fetch_queue;

  logic        clk, reset, validf, singlef, flushd, readyf, validd, validd2;
  logic [31:0] instrf, instrf2, pcplus4f, instrd, instrd2, pcplus4d, pcplus4d2;
  logic [1:0]  taked;
  logic [3:0]  count;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stallcnt;
`endif

  int checks = 0;
  int errors = 0;
  int stall_exp = 0;
  logic [63:0] mq[$];

  fetch_queue #(.DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .validf    (validf),
    .singlef   (singlef),
    .instrf    (instrf),
    .instrf2   (instrf2),
    .pcplus4f  (pcplus4f),
    .readyf    (readyf),
    .taked     (taked),
    .flushd    (flushd),
    .instrd    (instrd),
    .instrd2   (instrd2),
    .pcplus4d  (pcplus4d),
    .pcplus4d2 (pcplus4d2),
    .validd    (validd),
    .validd2   (validd2),
`ifdef FETCH_QUEUE_STATS_EN
    .stallcnt  (stallcnt),
`endif
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Applies one cycle of stimulus and advances the reference queue across the edge.
  task automatic drive(input logic v, input logic s, input logic [31:0] i1, input logic [31:0] i2,
                       input logic [31:0] pc, input logic [1:0] t, input logic fl, output logic acc);
    logic rdy;
    int   nd;
    validf = v; singlef = s; instrf = i1; instrf2 = i2; pcplus4f = pc; taked = t; flushd = fl;
    rdy = !reset && ((8 - mq.size()) >= 2);
    acc = v && rdy && !fl;
    if (v && !rdy && !reset) stall_exp++;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      stall_exp = 0;
    end else if (fl) begin
      mq.delete();
    end else begin
      nd = (int'(t) > mq.size()) ? mq.size() : int'(t);
      repeat (nd) void'(mq.pop_front());
      if (acc) begin
        mq.push_back({i1, pc});
        if (!s) mq.push_back({i2, pc + 32'd4});
      end
    end
    #1;
    validf = 1'b0; singlef = 1'b0; taked = 2'd0; flushd = 1'b0;
  endtask

  task automatic do_reset();
    logic acc;
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, acc);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic acc;
    reset = 1'b1; validf = 0; singlef = 0; flushd = 0; taked = 0;
    instrf = 0; instrf2 = 0; pcplus4f = 0;
    #1;
    checks++; if (readyf !== 1'b0) begin errors++; $display("FAIL reset_readyf got %b exp 0", readyf); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    drive(1'b1, 1'b0, 32'hDEAD0001, 32'hDEAD0002, 32'h100, 2'd0, 1'b0, acc);
    drive(1'b1, 1'b0, 32'hDEAD0001, 32'hDEAD0002, 32'h100, 2'd0, 1'b0, acc);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_hold_count got %0d exp 0", count); end
    checks++; if (validd !== 1'b0 || validd2 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b%b exp 00", validd, validd2); end
    checks++; if (instrd !== 32'h0 || pcplus4d !== 32'h0) begin errors++; $display("FAIL reset_data got %h %h exp 0 0", instrd, pcplus4d); end
    reset = 1'b0;
    #1;
    checks++; if (readyf !== 1'b1) begin errors++; $display("FAIL reset_release_readyf got %b exp 1", readyf); end
  endtask

  task automatic test_basic();
    logic acc;
    validf = 1; singlef = 0; instrf = 32'h20080001; instrf2 = 32'h20090002; pcplus4f = 32'h00400004;
    #1;
    checks++; if (validd !== 1'b0) begin errors++; $display("FAIL basic_no_bypass got %b exp 0", validd); end
    drive(1'b1, 1'b0, 32'h20080001, 32'h20090002, 32'h00400004, 2'd0, 1'b0, acc);
    checks++; if (validd !== 1'b1 || validd2 !== 1'b1) begin errors++; $display("FAIL basic_valid got %b%b exp 11", validd, validd2); end
    checks++; if (instrd !== 32'h20080001 || instrd2 !== 32'h20090002) begin errors++; $display("FAIL basic_instr got %h %h exp 20080001 20090002", instrd, instrd2); end
    checks++; if (pcplus4d !== 32'h00400004 || pcplus4d2 !== 32'h00400008) begin errors++; $display("FAIL basic_pc got %h %h exp 00400004 00400008", pcplus4d, pcplus4d2); end
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL basic_count got %0d exp 2", count); end
  endtask

  task automatic test_full();
    logic acc;
    do_reset();
    for (int k = 0; k < 4; k++)
      drive(1'b1, 1'b0, 32'h1000 + 2*k, 32'h1001 + 2*k, 32'h2000 + 8*k, 2'd0, 1'b0, acc);
    checks++; if (count !== 4'd8 || readyf !== 1'b0) begin errors++; $display("FAIL full_state got count %0d readyf %b exp 8 0", count, readyf); end
    drive(1'b1, 1'b0, 32'hBAD0, 32'hBAD1, 32'h9000, 2'd0, 1'b0, acc);
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_drop_count got %0d exp 8", count); end
    checks++; if (instrd !== 32'h1000 || instrd2 !== 32'h1001) begin errors++; $display("FAIL full_head got %h %h exp 1000 1001", instrd, instrd2); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, acc);
    checks++; if (count !== 4'd6 || readyf !== 1'b1) begin errors++; $display("FAIL full_take2 got count %0d readyf %b exp 6 1", count, readyf); end
    checks++; if (instrd !== 32'h1002 || pcplus4d !== 32'h2008) begin errors++; $display("FAIL full_newhead got %h %h exp 1002 2008", instrd, pcplus4d); end
  endtask

  task automatic test_underflow();
    logic acc;
    do_reset();
    drive(1'b1, 1'b1, 32'h00001234, 32'hFFFFFFFF, 32'h00400100, 2'd0, 1'b0, acc);
    checks++; if (count !== 4'd1 || validd2 !== 1'b0 || instrd2 !== 32'h0) begin errors++; $display("FAIL single_state got count %0d v2 %b i2 %h exp 1 0 0", count, validd2, instrd2); end
    checks++; if (instrd !== 32'h00001234 || pcplus4d !== 32'h00400100) begin errors++; $display("FAIL single_head got %h %h exp 00001234 00400100", instrd, pcplus4d); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, acc);
    checks++; if (count !== 4'd0 || validd !== 1'b0 || instrd !== 32'h0 || pcplus4d !== 32'h0) begin errors++; $display("FAIL underflow got count %0d v %b i %h pc %h exp 0 0 0 0", count, validd, instrd, pcplus4d); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, acc);
    checks++; if (count !== 4'd0 || readyf !== 1'b1) begin errors++; $display("FAIL underflow_empty got count %0d readyf %b exp 0 1", count, readyf); end
  endtask

  task automatic test_simultaneous();
    logic acc;
    do_reset();
    drive(1'b1, 1'b0, 32'h3000, 32'h3001, 32'h4004, 2'd0, 1'b0, acc);
    drive(1'b1, 1'b1, 32'h3002, 32'h0, 32'h400C, 2'd0, 1'b0, acc);
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL simul_pre_count got %0d exp 3", count); end
    drive(1'b1, 1'b0, 32'h3003, 32'h3004, 32'h4010, 2'd1, 1'b0, acc);
    checks++; if (count !== 4'd4) begin errors++; $display("FAIL simul_count got %0d exp 4", count); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (instrd !== 32'h3001 + k || pcplus4d !== mq[0][31:0]) begin
        errors++; $display("FAIL simul_order_%0d got %h %h exp %h %h", k, instrd, pcplus4d, 32'h3001 + k, mq[0][31:0]);
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd1, 1'b0, acc);
    end
  endtask

  task automatic test_flush();
    logic acc;
    do_reset();
    for (int k = 0; k < 3; k++)
      drive(1'b1, 1'b0, 32'h5000 + 2*k, 32'h5001 + 2*k, 32'h6000 + 8*k, 2'd0, 1'b0, acc);
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL flush_pre_count got %0d exp 6", count); end
    drive(1'b1, 1'b0, 32'h7000, 32'h7001, 32'h8004, 2'd1, 1'b1, acc);
    checks++; if (count !== 4'd0 || validd !== 1'b0) begin errors++; $display("FAIL flush got count %0d v %b exp 0 0", count, validd); end
    drive(1'b1, 1'b0, 32'h7100, 32'h7101, 32'h8104, 2'd0, 1'b0, acc);
    checks++; if (count !== 4'd2 || instrd !== 32'h7100 || pcplus4d2 !== 32'h8108) begin errors++; $display("FAIL flush_after got count %0d i %h pc2 %h exp 2 7100 8108", count, instrd, pcplus4d2); end
  endtask

  task automatic test_reset_mid();
    logic acc;
    drive(1'b1, 1'b0, 32'hA0, 32'hA1, 32'hB4, 2'd0, 1'b0, acc);
    reset = 1'b1;
    #1;
    checks++; if (readyf !== 1'b0 || validd !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL midreset got readyf %b v %b count %0d exp 0 0 0", readyf, validd, count); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, acc);
    reset = 1'b0;
    #1;
    checks++; if (readyf !== 1'b1 || count !== 4'd0 || validd !== 1'b0) begin errors++; $display("FAIL midreset_release got readyf %b count %0d v %b exp 1 0 0", readyf, count, validd); end
  endtask

  task automatic test_stream();
    logic       acc, s;
    logic [1:0] t;
    int         j, n, cyc;
    do_reset();
    j = 0; cyc = 0; s = 1'b0;
    while (j < 20 || mq.size() > 0) begin
      if (cyc > 2000) begin
        errors++; $display("FAIL stream_timeout got %0d pairs exp 20", j);
        break;
      end
      t = 2'($urandom_range(0, 2));
      if (j >= 20) t = 2'd2;
      n = (int'(t) > mq.size()) ? mq.size() : int'(t);
      checks++; if (count !== 4'(mq.size()) || readyf !== ((8 - mq.size()) >= 2)) begin errors++; $display("FAIL stream_occ cyc %0d got count %0d readyf %b exp %0d", cyc, count, readyf, mq.size()); end
      if (n >= 1) begin
        checks++; if ({instrd, pcplus4d} !== mq[0]) begin errors++; $display("FAIL stream_head0 cyc %0d got %h%h exp %h", cyc, instrd, pcplus4d, mq[0]); end
      end
      if (n >= 2) begin
        checks++; if ({instrd2, pcplus4d2} !== mq[1]) begin errors++; $display("FAIL stream_head1 cyc %0d got %h%h exp %h", cyc, instrd2, pcplus4d2, mq[1]); end
      end
      if (j < 20)
        drive(1'b1, s, 32'hC000_0000 + 2*j, 32'hC000_0001 + 2*j, 32'h0040_0004 + 8*j, t, 1'b0, acc);
      else
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, t, 1'b0, acc);
      if (acc) begin
        j++;
        s = ($urandom_range(0, 3) == 0);
      end
      cyc++;
    end
`ifdef FETCH_QUEUE_STATS_EN
    checks++; if (stallcnt !== 32'(stall_exp)) begin errors++; $display("FAIL stream_stallcnt got %0d exp %0d", stallcnt, stall_exp); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_underflow();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    test_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
